// File: rtl/adc_pmod.sv
// adc_pmod: periodic dual-channel PMOD-AD1 capture. A sample timer starts a
// conversion, the serial frame is clocked in on both channels at once, and the
// 12-bit results are pushed to a tracking FIFO as a 4-byte LR little-endian frame.
module adc_pmod #(
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] sample_period,
  input  logic [10:0] fifo_space,
  output logic [7:0]  fifo_data,
  output logic        fifo_write,
  output logic        pmod_cs,
  output logic        pmod_sclk,
  input  logic [1:0]  pmod_din,
  input  logic        clear_status,
  output logic [1:0]  status,
  output logic [31:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2,
    PUSH  = 2'd3
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYCLES - 1);

  state_t      state_r;
  logic [15:0] timer_r;
  logic [7:0]  div_r;
  logic [4:0]  bit_r;
  logic [15:0] quiet_r;
  logic [1:0]  byte_r;
  // Only the low 12 bits of each 16-bit serial word are kept; the four
  // leading bits simply shift out of the top.
  logic [11:0] sh_l_r;
  logic [11:0] sh_r_r;

  logic [15:0] sp_eff_s;
  logic        tick_s;
  logic        drop_s;
  logic        miss_s;
  logic [1:0]  status_next_s;

  // Effective period, sample tick, and the sticky status set/clear merge.
  always_comb begin
    sp_eff_s = sample_period;
    if (sample_period < 16'd2) begin
      sp_eff_s = 16'd2;
    end else begin
      sp_eff_s = sample_period;
    end
    tick_s        = enable && (timer_r >= (sp_eff_s - 16'd1));
    drop_s        = (state_r == PUSH) && (byte_r == 2'd0) && (fifo_space < 11'd4);
    miss_s        = tick_s && (state_r != IDLE);
    status_next_s = (status & ~{2{clear_status}}) | {miss_s, drop_s};
  end

  // Sample timer: free-runs 0..period-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r <= 16'd0;
    end else if (!enable || tick_s) begin
      timer_r <= 16'd0;
    end else begin
      timer_r <= timer_r + 16'd1;
    end
  end

  // Sticky status flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status <= 2'b00;
    end else begin
      status <= status_next_s;
    end
  end

  // Conversion FSM: serial capture, CS quiet time, then frame push or drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      div_r       <= 8'd0;
      bit_r       <= 5'd0;
      quiet_r     <= 16'd0;
      byte_r      <= 2'd0;
      sh_l_r      <= 12'd0;
      sh_r_r      <= 12'd0;
      pmod_cs     <= 1'b1;
      pmod_sclk   <= 1'b1;
      fifo_write  <= 1'b0;
      fifo_data   <= 8'd0;
      frame_count <= 32'd0;
    end else begin
      fifo_write <= 1'b0;
      case (state_r)
        IDLE: begin
          pmod_cs   <= 1'b1;
          pmod_sclk <= 1'b1;
          if (tick_s) begin
            state_r <= CONV;
            pmod_cs <= 1'b0;
            div_r   <= 8'd0;
            bit_r   <= 5'd0;
          end
        end
        CONV: begin
          if (div_r == DIV_LAST) begin
            div_r     <= 8'd0;
            pmod_sclk <= ~pmod_sclk;
            if (!pmod_sclk) begin
              // Rising SCLK edge: capture both channels MSB first.
              sh_l_r <= {sh_l_r[10:0], pmod_din[0]};
              sh_r_r <= {sh_r_r[10:0], pmod_din[1]};
              if (bit_r == 5'd15) begin
                pmod_cs <= 1'b1;
                bit_r   <= 5'd0;
                quiet_r <= 16'd0;
                state_r <= QUIET;
              end else begin
                bit_r <= bit_r + 5'd1;
              end
            end
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        QUIET: begin
          if (quiet_r == QUIET_LAST) begin
            byte_r  <= 2'd0;
            state_r <= PUSH;
          end else begin
            quiet_r <= quiet_r + 16'd1;
          end
        end
        PUSH: begin
          case (byte_r)
            2'd0: begin
              // Room is checked once, up front, so a frame is all-or-nothing.
              if (fifo_space < 11'd4) begin
                state_r <= IDLE;
              end else begin
                fifo_write <= 1'b1;
                fifo_data  <= sh_l_r[7:0];
                byte_r     <= 2'd1;
              end
            end
            2'd1: begin
              fifo_write <= 1'b1;
              fifo_data  <= {4'd0, sh_l_r[11:8]};
              byte_r     <= 2'd2;
            end
            2'd2: begin
              fifo_write <= 1'b1;
              fifo_data  <= sh_r_r[7:0];
              byte_r     <= 2'd3;
            end
            2'd3: begin
              fifo_write  <= 1'b1;
              fifo_data   <= {4'd0, sh_r_r[11:8]};
              frame_count <= frame_count + 32'd1;
              byte_r      <= 2'd0;
              state_r     <= IDLE;
            end
            default: begin
              byte_r  <= 2'd0;
              state_r <= IDLE;
            end
          endcase
        end
        default: begin
          state_r   <= IDLE;
          pmod_cs   <= 1'b1;
          pmod_sclk <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_pmod.sv
// tb_adc_pmod: directed scenario tests for adc_pmod with a PMOD-AD1 serial model.
module tb_adc_pmod;

  localparam int QUIET = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sample_period;
  logic [10:0] fifo_space;
  logic [7:0]  fifo_data;
  logic        fifo_write;
  logic        pmod_cs;
  logic        pmod_sclk;
  logic [1:0]  pmod_din;
  logic        clear_status;
  logic [1:0]  status;
  logic [31:0] frame_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] l_word = 16'hFABC;
  logic [15:0] r_word = 16'hF123;
  logic [7:0]  exp_bytes [4] = '{8'hBC, 8'h0A, 8'h23, 8'h01};

  logic [7:0] bytes_q [$];
  logic cs_prev = 1'b1;
  logic sclk_prev = 1'b1;
  int low_len = 0, high_len = 0, rises = 0;
  int last_low = 0, last_rises = 0, windows = 0, win_bad = 0;
  int bidx = 15;

  adc_pmod #(.CLK_DIV(4), .QUIET_CYCLES(QUIET)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_period(sample_period),
    .fifo_space(fifo_space), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .pmod_cs(pmod_cs), .pmod_sclk(pmod_sclk), .pmod_din(pmod_din),
    .clear_status(clear_status), .status(status), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Converter model: restart the word on CS fall, present next bit on SCLK fall.
  always @(negedge pmod_cs) bidx = 15;
  always @(negedge pmod_sclk) begin
    if (pmod_cs == 1'b0 && bidx >= 0) begin
      pmod_din = {r_word[bidx], l_word[bidx]};
      bidx--;
    end
  end

  // Bus monitor: collect bytes, measure CS windows and SCLK rising edges.
  always @(negedge clk) begin
    if (!reset) begin
      cs_prev = 1'b1; sclk_prev = 1'b1; low_len = 0; rises = 0; high_len = 0;
    end else begin
      if (fifo_write) bytes_q.push_back(fifo_data);
      if (!cs_prev && !sclk_prev && pmod_sclk) rises++;
      if (!pmod_cs) begin
        if (cs_prev && windows > 0 && high_len < QUIET) win_bad++;
        low_len++;
        high_len = 0;
      end else begin
        if (!cs_prev) begin
          last_low = low_len; last_rises = rises; windows++;
          if (low_len != 128 || rises != 16) win_bad++;
          low_len = 0; rises = 0;
        end
        high_len++;
      end
      cs_prev = pmod_cs;
      sclk_prev = pmod_sclk;
    end
  end

  task automatic run_frame(input logic [15:0] sp, output int latency);
    int n;
    n = 0;
    sample_period = sp;
    enable = 1'b1;
    while (pmod_cs !== 1'b0 && n < int'(sp) + 20) begin
      @(negedge clk);
      n++;
    end
    latency = n;
    enable = 1'b0;
    total++;
    if (pmod_cs !== 1'b0) begin
      bad++;
      $display("FAIL frame_start: cs=%b after %0d cycles, expected 0", pmod_cs, n);
    end
    repeat (200) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; clear_status = 1'b0;
    sample_period = 16'd300; fifo_space = 11'd100; pmod_din = 2'b00;
    repeat (5) @(negedge clk);
    total += 6;
    if (pmod_cs !== 1'b1)      begin bad++; $display("FAIL rst_cs: got %b want 1", pmod_cs); end
    if (pmod_sclk !== 1'b1)    begin bad++; $display("FAIL rst_sclk: got %b want 1", pmod_sclk); end
    if (fifo_write !== 1'b0)   begin bad++; $display("FAIL rst_wr: got %b want 0", fifo_write); end
    if (fifo_data !== 8'h00)   begin bad++; $display("FAIL rst_data: got %h want 00", fifo_data); end
    if (status !== 2'b00)      begin bad++; $display("FAIL rst_status: got %b want 00", status); end
    if (frame_count !== 32'd0) begin bad++; $display("FAIL rst_fc: got %0d want 0", frame_count); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int lat;
    bytes_q.delete(); windows = 0; win_bad = 0;
    run_frame(16'd300, lat);
    total += 10;
    if (lat != 300) begin bad++; $display("FAIL first_tick: cs low after %0d cycles, want 300", lat); end
    if (bytes_q.size() != 4) begin bad++; $display("FAIL frame_len: got %0d bytes want 4", bytes_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (bytes_q[i] !== exp_bytes[i]) begin
        bad++; $display("FAIL frame_byte%0d: got %h want %h", i, bytes_q[i], exp_bytes[i]);
      end
    end
    if (frame_count !== 32'd1) begin bad++; $display("FAIL frame_fc: got %0d want 1", frame_count); end
    if (status !== 2'b00) begin bad++; $display("FAIL frame_status: got %b want 00", status); end
    if (last_rises != 16) begin bad++; $display("FAIL sclk_rises: got %0d want 16", last_rises); end
    if (last_low != 128) begin bad++; $display("FAIL cs_low_len: got %0d want 128", last_low); end
  endtask

  task automatic test_drop();
    int lat;
    bytes_q.delete();
    fifo_space = 11'd3;
    run_frame(16'd300, lat);
    total += 3;
    if (bytes_q.size() != 0) begin bad++; $display("FAIL drop_len: got %0d bytes want 0", bytes_q.size()); end
    if (status !== 2'b01) begin bad++; $display("FAIL drop_status: got %b want 01", status); end
    if (frame_count !== 32'd1) begin bad++; $display("FAIL drop_fc: got %0d want 1", frame_count); end
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    @(negedge clk);
    total++;
    if (status !== 2'b00) begin bad++; $display("FAIL clear_status: got %b want 00", status); end
    fifo_space = 11'd100;
  endtask

  task automatic test_overrun();
    int nfr, grp_bad;
    bytes_q.delete(); windows = 0; win_bad = 0; grp_bad = 0;
    sample_period = 16'd50;
    enable = 1'b1;
    repeat (700) @(negedge clk);
    enable = 1'b0;
    repeat (250) @(negedge clk);
    nfr = bytes_q.size() / 4;
    for (int i = 0; i < nfr * 4; i++) begin
      if (bytes_q[i] !== exp_bytes[i % 4]) grp_bad++;
    end
    total += 7;
    if (status !== 2'b10) begin bad++; $display("FAIL ovr_status: got %b want 10", status); end
    if (bytes_q.size() % 4 != 0) begin bad++; $display("FAIL ovr_partial: got %0d bytes, want multiple of 4", bytes_q.size()); end
    if (nfr < 3) begin bad++; $display("FAIL ovr_frames: got %0d frames want at least 3", nfr); end
    if (grp_bad != 0) begin bad++; $display("FAIL ovr_bytes: got %0d wrong bytes want 0", grp_bad); end
    if (frame_count !== 32'(1 + nfr)) begin bad++; $display("FAIL ovr_fc: got %0d want %0d", frame_count, 1 + nfr); end
    if (win_bad != 0) begin bad++; $display("FAIL ovr_cs_glitch: got %0d bad windows want 0", win_bad); end
    if (windows != nfr) begin bad++; $display("FAIL ovr_windows: got %0d windows want %0d", windows, nfr); end
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
  endtask

  task automatic test_reset_push();
    int n, lat;
    n = 0;
    sample_period = 16'd300;
    enable = 1'b1;
    while (fifo_write !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    total++;
    if (fifo_write !== 1'b1) begin bad++; $display("FAIL push_start: fifo_write=%b want 1", fifo_write); end
    @(negedge clk);
    total++;
    if (fifo_data !== 8'h0A) begin bad++; $display("FAIL push_byte2: got %h want 0a", fifo_data); end
    reset = 1'b0;
    #1;
    total += 6;
    if (fifo_write !== 1'b0)   begin bad++; $display("FAIL abort_wr: got %b want 0", fifo_write); end
    if (pmod_cs !== 1'b1)      begin bad++; $display("FAIL abort_cs: got %b want 1", pmod_cs); end
    if (pmod_sclk !== 1'b1)    begin bad++; $display("FAIL abort_sclk: got %b want 1", pmod_sclk); end
    if (fifo_data !== 8'h00)   begin bad++; $display("FAIL abort_data: got %h want 00", fifo_data); end
    if (status !== 2'b00)      begin bad++; $display("FAIL abort_status: got %b want 00", status); end
    if (frame_count !== 32'd0) begin bad++; $display("FAIL abort_fc: got %0d want 0", frame_count); end
    @(negedge clk);
    reset = 1'b1;
    bytes_q.delete(); windows = 0; win_bad = 0;
    run_frame(16'd300, lat);
    total += 2;
    if (bytes_q.size() != 4 || bytes_q[0] !== 8'hBC || bytes_q[1] !== 8'h0A ||
        bytes_q[2] !== 8'h23 || bytes_q[3] !== 8'h01) begin
      bad++; $display("FAIL post_reset_frame: got %0d bytes, first %h want 4 bytes bc 0a 23 01", bytes_q.size(), bytes_q[0]);
    end
    if (frame_count !== 32'd1) begin bad++; $display("FAIL post_reset_fc: got %0d want 1", frame_count); end
  endtask

  task automatic test_wrap();
    int lat;
    force dut.frame_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_count;
    @(negedge clk);
    total++;
    if (frame_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffffffff", frame_count); end
    bytes_q.delete();
    run_frame(16'd300, lat);
    total += 2;
    if (frame_count !== 32'd0) begin bad++; $display("FAIL wrap_fc: got %h want 00000000", frame_count); end
    if (bytes_q.size() != 4) begin bad++; $display("FAIL wrap_len: got %0d bytes want 4", bytes_q.size()); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_drop();
    test_overrun();
    test_reset_push();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
